// File: rtl/lcd_bus_sequencer.sv
// HD44780 character-LCD write-bus owner: runs the power-up init sequence, then
// round-robins byte writes from two requesters with setup/enable/execution timing.
module lcd_bus_sequencer #(
   parameter int unsigned SETUP_CYC      = 4,
   parameter int unsigned EN_CYC         = 12,
   parameter int unsigned WAIT_CYC       = 2500,
   parameter int unsigned CLEAR_WAIT_CYC = 82000,
   parameter int unsigned INIT_WAIT_CYC  = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       init_done,
   output logic       busy,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en
);

   localparam int unsigned MaxA   = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC
                                                                     : CLEAR_WAIT_CYC;
   localparam int unsigned MaxB   = (WAIT_CYC > EN_CYC) ? WAIT_CYC : EN_CYC;
   localparam int unsigned MaxC   = (MaxB > SETUP_CYC) ? MaxB : SETUP_CYC;
   localparam int unsigned MaxCyc = (MaxA > MaxC) ? MaxA : MaxC;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   typedef enum logic [2:0] {
      StInitWait,
      StIdle,
      StSetup,
      StPulse,
      StWait
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        init_idx_q, init_idx_d;
   logic [1:0]        init_idx_next;
   logic              init_done_q, init_done_d;
   logic              last_grant_q, last_grant_d;
   logic              lcd_rs_q, lcd_rs_d;
   logic [7:0]        lcd_data_q, lcd_data_d;
   logic              lcd_en_q, lcd_en_d;
   logic              accept_ok;
   logic              is_clear;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      unique case (idx)
         2'd0: return 8'h38;
         2'd1: return 8'h0C;
         2'd2: return 8'h01;
         2'd3: return 8'h06;
      endcase
   endfunction

   // On a tie the requester that did not win last time is granted.
   assign accept_ok  = (state_q == StIdle) && init_done_q;
   assign req0_ready = accept_ok && req0_valid && (!req1_valid || last_grant_q);
   assign req1_ready = accept_ok && req1_valid && (!req0_valid || !last_grant_q);

   assign is_clear      = !lcd_rs_q && ((lcd_data_q == 8'h01) || (lcd_data_q == 8'h02));
   assign init_idx_next = init_idx_q + 2'd1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      init_idx_d   = init_idx_q;
      init_done_d  = init_done_q;
      last_grant_d = last_grant_q;
      lcd_rs_d     = lcd_rs_q;
      lcd_data_d   = lcd_data_q;
      lcd_en_d     = lcd_en_q;

      unique case (state_q)
         StInitWait: begin
            if (cnt_q == '0) begin
               state_d    = StSetup;
               cnt_d      = CntW'(SETUP_CYC - 1);
               init_idx_d = 2'd0;
               lcd_rs_d   = 1'b0;
               lcd_data_d = init_cmd(2'd0);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StIdle: begin
            if (req0_ready) begin
               state_d      = StSetup;
               cnt_d        = CntW'(SETUP_CYC - 1);
               last_grant_d = 1'b0;
               lcd_rs_d     = req0_rs;
               lcd_data_d   = req0_data;
            end else if (req1_ready) begin
               state_d      = StSetup;
               cnt_d        = CntW'(SETUP_CYC - 1);
               last_grant_d = 1'b1;
               lcd_rs_d     = req1_rs;
               lcd_data_d   = req1_data;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d  = StPulse;
               cnt_d    = CntW'(EN_CYC - 1);
               lcd_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StPulse: begin
            if (cnt_q == '0) begin
               state_d  = StWait;
               cnt_d    = is_clear ? CntW'(CLEAR_WAIT_CYC - 1) : CntW'(WAIT_CYC - 1);
               lcd_en_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (init_done_q) begin
               state_d = StIdle;
            end else if (init_idx_q == 2'd3) begin
               state_d     = StIdle;
               init_done_d = 1'b1;
            end else begin
               state_d    = StSetup;
               cnt_d      = CntW'(SETUP_CYC - 1);
               init_idx_d = init_idx_next;
               lcd_rs_d   = 1'b0;
               lcd_data_d = init_cmd(init_idx_next);
            end
         end
         default: begin
            state_d = StInitWait;
            cnt_d   = CntW'(INIT_WAIT_CYC);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StInitWait;
         cnt_q        <= CntW'(INIT_WAIT_CYC);
         init_idx_q   <= 2'd0;
         init_done_q  <= 1'b0;
         last_grant_q <= 1'b1;
         lcd_rs_q     <= 1'b0;
         lcd_data_q   <= 8'h00;
         lcd_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         init_idx_q   <= init_idx_d;
         init_done_q  <= init_done_d;
         last_grant_q <= last_grant_d;
         lcd_rs_q     <= lcd_rs_d;
         lcd_data_q   <= lcd_data_d;
         lcd_en_q     <= lcd_en_d;
      end
   end

   assign init_done = init_done_q;
   assign busy      = (state_q != StIdle);
   assign lcd_data  = lcd_data_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = lcd_en_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized bench for lcd_bus_sequencer: a transaction-level timeline model predicts
// every bus/handshake output for each clock window.
module tb_lcd_bus_sequencer;

   localparam int unsigned S  = 2;
   localparam int unsigned E  = 3;
   localparam int unsigned WC = 5;
   localparam int unsigned CW = 20;
   localparam int unsigned IW = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
   logic [7:0] req0_data = 8'h00;
   logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
   logic [7:0] req1_data = 8'h00;
   logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   lcd_bus_sequencer #(
      .SETUP_CYC(S), .EN_CYC(E), .WAIT_CYC(WC), .CLEAR_WAIT_CYC(CW), .INIT_WAIT_CYC(IW)
   ) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .init_done(init_done), .busy(busy), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_en(lcd_en)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int win      = -1;   // index of the last rising edge with reset low; -1 right after reset

   logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Timeline model: each write occupies SETUP+EN+wait cycles starting at the edge tx_e.
   bit         prev_rst = 1'b1;
   bit         m_idle, m_done, last_g, tx_user;
   int         init_k, tx_e, tx_end;
   logic       tx_rs, exp_rs;
   logic [7:0] tx_data, exp_data;
   bit         exp_en, exp_r0, exp_r1;

   logic       v [2];
   logic       rs_r [2];
   logic [7:0] d_r [2];
   int         prob = 0;
   int         n_acc [2];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (window %0d)", tag, obs, exp, win);
   endtask

   function automatic int post_wait(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02)) ? CW : WC;
   endfunction

   task automatic model_reset();
      m_idle   = 1'b0;
      m_done   = 1'b0;
      last_g   = 1'b1;
      tx_user  = 1'b0;
      init_k   = -1;
      tx_e     = -1000;
      tx_end   = IW;
      exp_rs   = 1'b0;
      exp_data = 8'h00;
   endtask

   task automatic start_tx(input logic rs, input logic [7:0] d, input int e, input bit user);
      tx_e    = e;
      tx_rs   = rs;
      tx_data = d;
      tx_user = user;
      tx_end  = e + S + E + post_wait(rs, d);
      m_idle  = 1'b0;
   endtask

   task automatic gen_byte(input int i);
      int r;
      r = int'($urandom_range(0, 9));
      v[i] = 1'b1;
      case (r)
         0:       begin rs_r[i] = 1'b0; d_r[i] = 8'h01; end
         1:       begin rs_r[i] = 1'b0; d_r[i] = 8'h02; end
         2:       begin rs_r[i] = 1'b1; d_r[i] = 8'h01; end
         default: begin rs_r[i] = 1'($urandom); d_r[i] = 8'($urandom); end
      endcase
   endtask

   // One clock window: drive inputs after the falling edge, then predict and compare.
   task automatic step(input bit rst_next);
      @(negedge clk);
      if (prev_rst) begin
         model_reset();
         win = -1;
      end else begin
         win++;
      end
      reset = rst_next;
      for (int i = 0; i < 2; i++)
         if (!v[i] && int'($urandom_range(0, 99)) < prob) gen_byte(i);
      req0_valid = v[0]; req0_rs = rs_r[0]; req0_data = d_r[0];
      req1_valid = v[1]; req1_rs = rs_r[1]; req1_data = d_r[1];
      #1;
      if (!m_idle && win == tx_end) begin
         if (m_done) m_idle = 1'b1;
         else if (init_k == 3) begin
            m_done = 1'b1;
            m_idle = 1'b1;
         end else begin
            init_k++;
            start_tx(1'b0, init_tab[init_k], win, 1'b0);
         end
      end
      if (!m_idle && win == tx_e) begin
         exp_rs   = tx_rs;
         exp_data = tx_data;
      end
      exp_en = !m_idle && (win >= tx_e + int'(S)) && (win < tx_e + int'(S + E));
      exp_r0 = m_idle && m_done && v[0] && (!v[1] || last_g);
      exp_r1 = m_idle && m_done && v[1] && (!v[0] || !last_g);
      check_eq("lcd_en", lcd_en, exp_en);
      check_eq("lcd_rs", lcd_rs, exp_rs);
      check_eq("lcd_data", lcd_data, exp_data);
      check_eq("lcd_rw", lcd_rw, 1'b0);
      check_eq("busy", busy, !m_idle);
      check_eq("init_done", init_done, m_done);
      check_eq("req0_ready", req0_ready, exp_r0);
      check_eq("req1_ready", req1_ready, exp_r1);
      check_eq("ready_onehot", req0_ready & req1_ready, 1'b0);
      if (!rst_next) begin
         for (int i = 0; i < 2; i++) begin
            if ((i == 0 && exp_r0) || (i == 1 && exp_r1)) begin
               start_tx(rs_r[i], d_r[i], win + 1, 1'b1);
               last_g = 1'(i);
               v[i]   = 1'b0;
               n_acc[i]++;
            end
         end
      end
      prev_rst = rst_next;
   endtask

   initial begin
      bit found;
      v[0] = 1'b0; v[1] = 1'b0;
      rs_r[0] = 1'b0; rs_r[1] = 1'b0;
      d_r[0] = 8'h00; d_r[1] = 8'h00;
      n_acc[0] = 0; n_acc[1] = 0;

      // Power-up with a data byte from requester 0 already waiting.
      v[0] = 1'b1; rs_r[0] = 1'b1; d_r[0] = 8'h41;
      repeat (3) step(1'b1);
      repeat (120) step(1'b0);
      check_eq("req0_first_accepted", n_acc[0], 1);

      // Sparse random traffic from both requesters.
      prob = 30;
      repeat (700) step(1'b0);

      // Both requesters continuously valid: grants must alternate.
      prob = 100;
      repeat (500) step(1'b0);
      check_eq("both_served", (n_acc[0] > 5) && (n_acc[1] > 5), 1'b1);

      // Reset while a user byte is being strobed.
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         step(1'b0);
         if (tx_user && exp_en && win < tx_e + int'(S + E) - 1) found = 1'b1;
      end
      check_eq("mid_reset_found", found, 1'b1);
      repeat (2) step(1'b1);
      step(1'b0);
      check_eq("post_reset_en_low", lcd_en, 1'b0);
      prob = 0;
      v[0] = 1'b0; v[1] = 1'b0;
      repeat (100) step(1'b0);
      check_eq("reinit_done", init_done, 1'b1);

      prob = 60;
      repeat (400) step(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
